// File: rtl/renode_apb4_requester_pkg.sv
// renode_apb4_pkg: shared types for the Renode APB4 requester
// Provides the response status codes, the requester FSM states, the APB
// protection type and a helper that sizes the completer index.
package renode_apb4_pkg;

    typedef enum logic [1:0] {
        OKAY    = 2'd0,
        SLVERR  = 2'd1,
        DECERR  = 2'd2,
        TIMEOUT = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    typedef logic [2:0] prot_t;

    // A single completer still needs a one-bit index to keep vectors legal.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/renode_apb4_requester_if.sv
// renode_apb4_requester_if: Renode request/response and APB4 completer bundle
// Request side : req_valid/req_ready handshake with addr, write, wdata, strb, prot
// Response side: rsp_valid/rsp_ready handshake with rdata and status
// APB side     : paddr, psel[SlaveCount], penable, pwrite, pwdata, pstrb, pprot
//                out; pready[SlaveCount], prdata[SlaveCount*DataWidth],
//                pslverr[SlaveCount] in
// master modport is the requester view, slave modport the environment view.
interface renode_apb4_requester_if
    import renode_apb4_pkg::*;
#(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32,
    parameter int SlaveCount   = 1
);
    logic                         req_valid;
    logic                         req_ready;
    logic [AddressWidth-1:0]      req_addr;
    logic                         req_write;
    logic [DataWidth-1:0]         req_wdata;
    logic [DataWidth/8-1:0]       req_strb;
    prot_t                        req_prot;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [DataWidth-1:0]         rsp_rdata;
    status_e                      rsp_status;
    logic [AddressWidth-1:0]      paddr;
    logic [SlaveCount-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [DataWidth-1:0]         pwdata;
    logic [DataWidth/8-1:0]       pstrb;
    prot_t                        pprot;
    logic [SlaveCount-1:0]        pready;
    logic [SlaveCount*DataWidth-1:0] prdata;
    logic [SlaveCount-1:0]        pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        input  rsp_ready, pready, prdata, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_status,
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        output rsp_ready, pready, prdata, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_status,
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot
    );

endinterface

// File: rtl/renode_apb4_decoder.sv
// renode_apb4_decoder: byte address to completer index and decode-error flag
// addr    in  AddressWidth : request byte address
// idx     out SelWidth     : completer index taken from the top address bits
// dec_err out 1            : index does not name an existing completer
module renode_apb4_decoder
    import renode_apb4_pkg::*;
#(
    parameter int AddressWidth = 20,
    parameter int SlaveCount   = 1,
    localparam int SelWidth    = sel_width(SlaveCount)
) (
    input  logic [AddressWidth-1:0] addr,
    output logic [SelWidth-1:0]     idx,
    output logic                    dec_err
);
    // Only the top bits select a completer; the rest belong to the completer.
    logic unused_addr;
    assign unused_addr = ^addr;

    if (SlaveCount > 1) begin : g_multi
        assign idx     = addr[AddressWidth-1 -: SelWidth];
        assign dec_err = {1'b0, idx} >= (SelWidth + 1)'(SlaveCount);
    end else begin : g_single
        assign idx     = '0;
        assign dec_err = 1'b0;
    end

endmodule

// File: rtl/renode_apb4_requester.sv
// renode_apb4_requester: single-beat Renode bus requests to APB4 transfers
// pclk   in : clock
// preset in : asynchronous active-high reset
// bus       : renode_apb4_requester_if.master carrying the request, response
//             and multi-completer APB4 signals
module renode_apb4_requester
    import renode_apb4_pkg::*;
#(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int SlaveCount    = 1,
    parameter int TimeoutCycles = 256
) (
    input  logic                    pclk,
    input  logic                    preset,
    renode_apb4_requester_if.master bus
);
    localparam int SelWidth  = sel_width(SlaveCount);
    localparam int StrbWidth = DataWidth / 8;
    localparam int CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    if (DataWidth != 8 && DataWidth != 16 && DataWidth != 24 && DataWidth != 32) begin : g_bad_width
        $error("renode_apb4_requester: DataWidth %0d is not 8, 16, 24 or 32", DataWidth);
    end

    if (SlaveCount < 1 || SlaveCount > 16) begin : g_bad_count
        $error("renode_apb4_requester: SlaveCount %0d outside 1..16", SlaveCount);
    end

    state_e                  state, state_n;
    logic [AddressWidth-1:0] addr_q;
    logic                    write_q;
    logic [DataWidth-1:0]    wdata_q;
    logic [StrbWidth-1:0]    strb_q;
    prot_t                   prot_q;
    logic [SelWidth-1:0]     idx, idx_q;
    logic                    dec_err;
    logic [DataWidth-1:0]    rdata_q;
    status_e                 status_q;
    logic [CntWidth-1:0]     cnt_q, cnt_inc;
    logic                    sel_ready, sel_err, timeout, active;
    logic [DataWidth-1:0]    sel_rdata;
    logic [SlaveCount-1:0]   onehot;

    renode_apb4_decoder #(
        .AddressWidth(AddressWidth),
        .SlaveCount  (SlaveCount)
    ) u_decoder (
        .addr   (bus.req_addr),
        .idx    (idx),
        .dec_err(dec_err)
    );

    // Only the registered completer is listened to; other lanes are ignored.
    assign sel_ready = bus.pready[idx_q];
    assign sel_err   = bus.pslverr[idx_q];
    assign sel_rdata = bus.prdata[idx_q*DataWidth +: DataWidth];
    assign onehot    = SlaveCount'(1) << idx_q;
    assign active    = (state == SETUP) || (state == ACCESS);

    // cnt_inc is the number of ACCESS cycles without pready including this one.
    assign cnt_inc = cnt_q + 1'b1;
    assign timeout = (TimeoutCycles != 0) && (cnt_inc == CntWidth'(TimeoutCycles));

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.req_valid ? (dec_err ? RESP : SETUP) : IDLE;
            SETUP:   state_n = ACCESS;
            ACCESS:  state_n = (sel_ready || timeout) ? RESP : ACCESS;
            RESP:    state_n = bus.rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prot_q   <= '0;
            idx_q    <= '0;
            rdata_q  <= '0;
            status_q <= OKAY;
            cnt_q    <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                addr_q   <= bus.req_addr;
                write_q  <= bus.req_write;
                wdata_q  <= bus.req_write ? bus.req_wdata : '0;
                strb_q   <= bus.req_write ? bus.req_strb : '0;
                prot_q   <= bus.req_prot;
                idx_q    <= idx;
                rdata_q  <= '0;
                status_q <= dec_err ? DECERR : OKAY;
            end
            if (state == SETUP) cnt_q <= '0;
            if (state == ACCESS) begin
                // pready outranks a timeout landing in the same cycle.
                if (sel_ready) begin
                    rdata_q  <= (!write_q && !sel_err) ? sel_rdata : '0;
                    status_q <= sel_err ? SLVERR : OKAY;
                end else if (timeout) begin
                    status_q <= TIMEOUT;
                end else begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

    assign bus.req_ready  = state == IDLE;
    assign bus.rsp_valid  = state == RESP;
    assign bus.rsp_rdata  = (state == RESP) ? rdata_q : '0;
    assign bus.rsp_status = (state == RESP) ? status_q : OKAY;
    assign bus.psel       = active ? onehot : '0;
    assign bus.penable    = state == ACCESS;
    assign bus.paddr      = active ? addr_q : '0;
    assign bus.pwrite     = active && write_q;
    assign bus.pwdata     = active ? wdata_q : '0;
    assign bus.pstrb      = active ? strb_q : '0;
    assign bus.pprot      = active ? prot_q : '0;

endmodule

// File: tb/tb_renode_apb4_requester.sv
// tb_renode_apb4_requester: directed and random checks of the APB4 requester
module tb_renode_apb4_requester;
    import renode_apb4_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int SC = 4;
    localparam int TO = 8;
    localparam int SW = DW / 8;
    localparam logic [DW-1:0] INIT [SC] = '{32'h0BAD_F00D, 32'hC0FF_EE11, 32'hDEAD_BEEF, 32'h55AA_33CC};
    localparam logic [DW-1:0] D3 [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

    logic pclk = 1'b0;
    logic preset = 1'b1;
    int errors = 0;
    int checks = 0;
    int wait_n = 0;
    logic err_n = 1'b0;
    logic [7:0] acc_cnt;
    logic [SC-1:0] noise;
    logic [DW-1:0] cmem [SC];
    logic [DW-1:0] rmem [SC];

    always #5 pclk = ~pclk;

    renode_apb4_requester_if #(.AddressWidth(AW), .DataWidth(DW), .SlaveCount(SC)) bus ();
    renode_apb4_requester_if #(.AddressWidth(AW), .DataWidth(DW), .SlaveCount(3)) bus3 ();

    renode_apb4_requester #(
        .AddressWidth(AW), .DataWidth(DW), .SlaveCount(SC), .TimeoutCycles(TO)
    ) u_dut (
        .pclk(pclk), .preset(preset), .bus(bus.master)
    );

    renode_apb4_requester #(
        .AddressWidth(AW), .DataWidth(DW), .SlaveCount(3)
    ) u_dut3 (
        .pclk(pclk), .preset(preset), .bus(bus3.master)
    );

    // Completers: one word each, ready after wait_n ACCESS cycles; unselected
    // lanes show random pready and constant pslverr to catch mis-selection.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            acc_cnt <= '0;
            noise <= '0;
            for (int i = 0; i < SC; i++) cmem[i] <= INIT[i];
        end else begin
            acc_cnt <= bus.penable ? acc_cnt + 8'd1 : 8'd0;
            noise <= SC'($urandom);
            for (int i = 0; i < SC; i++)
                if (bus.psel[i] && bus.penable && bus.pready[i] && bus.pwrite && !bus.pslverr[i])
                    for (int b = 0; b < SW; b++)
                        if (bus.pstrb[b]) cmem[i][8*b +: 8] <= bus.pwdata[8*b +: 8];
        end
    end

    always_comb begin
        bus.pready = (noise & ~bus.psel) | ((bus.penable && int'(acc_cnt) >= wait_n) ? bus.psel : '0);
        bus.pslverr = ~bus.psel | (err_n ? bus.psel : '0);
        bus.prdata = '0;
        for (int i = 0; i < SC; i++) bus.prdata[i*DW +: DW] = cmem[i];
    end

    assign bus3.pready = 3'b111;
    assign bus3.pslverr = 3'b000;
    assign bus3.prdata = {D3[2], D3[1], D3[0]};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic handshake(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input prot_t p);
        int g = 0;
        bus.req_addr = a;
        bus.req_write = w;
        bus.req_wdata = d;
        bus.req_strb = s;
        bus.req_prot = p;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && g < 20) begin
            @(negedge pclk);
            g++;
        end
        chk("req_ready_wait", 64'(g < 20), 64'd1);
        @(posedge pclk);
    endtask

    // Expected outcome follows the protocol rules: status from wait/err/timeout,
    // latency 2 + ACCESS cycles, read data from the reference memory.
    task automatic run(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input prot_t p, input int wn,
                       input logic er, input int hold);
        int idx = int'(a[AW-1 -: 2]);
        logic [SC-1:0] oh = SC'(1) << idx;
        status_e es;
        status_e st0;
        logic [DW-1:0] exp_d, r0;
        logic [SC-1:0] s_psel;
        logic s_pen, held_bad, stable_bad;
        int acc, c, pen;
        es = (wn >= TO) ? TIMEOUT : (er ? SLVERR : OKAY);
        acc = (wn >= TO) ? TO : wn + 1;
        exp_d = (!w && es == OKAY) ? rmem[idx] : '0;
        wait_n = wn;
        err_n = er;
        handshake(a, w, d, s, p);
        c = 0;
        pen = 0;
        held_bad = 1'b0;
        s_psel = '0;
        s_pen = 1'b0;
        do begin
            @(negedge pclk);
            c++;
            if (c == 1) begin
                bus.req_valid = 1'b0;
                s_psel = bus.psel;
                s_pen = bus.penable;
            end
            if (bus.penable) pen++;
            if (bus.psel != '0 && (bus.psel !== oh || bus.paddr !== a || bus.pwrite !== w ||
                bus.pwdata !== (w ? d : '0) || bus.pstrb !== (w ? s : '0) || bus.pprot !== p))
                held_bad = 1'b1;
        end while (!bus.rsp_valid && c < 300);
        chk("latency", 64'(c), 64'(2 + acc));
        chk("penable_cycles", 64'(pen), 64'(acc));
        chk("setup_sel", {s_psel, s_pen}, {oh, 1'b0});
        chk("apb_fields", held_bad, 0);
        chk("apb_idle_in_resp", |{bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot}, 0);
        chk("rsp_status", bus.rsp_status, es);
        chk("rsp_rdata", bus.rsp_rdata, exp_d);
        if (w && es == OKAY)
            for (int b = 0; b < SW; b++)
                if (s[b]) rmem[idx][8*b +: 8] = d[8*b +: 8];
        r0 = bus.rsp_rdata;
        st0 = bus.rsp_status;
        stable_bad = 1'b0;
        repeat (hold) begin
            @(negedge pclk);
            if (!bus.rsp_valid || bus.req_ready || bus.rsp_rdata !== r0 || bus.rsp_status !== st0)
                stable_bad = 1'b1;
        end
        if (hold > 0) chk("backpressure", stable_bad, 0);
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        chk("rsp_consumed", {bus.rsp_valid, bus.req_ready}, 2'b01);
    endtask

    // Three-completer instance: index 3 must decode-error without touching APB.
    task automatic run3(input logic [AW-1:0] a);
        int idx = int'(a[AW-1 -: 2]);
        int c = 0;
        logic seen_sel = 1'b0;
        status_e es = (idx >= 3) ? DECERR : OKAY;
        logic [DW-1:0] ed = '0;
        if (idx < 3) ed = D3[idx];
        chk("dec_req_ready", bus3.req_ready, 1);
        bus3.req_addr = a;
        bus3.req_valid = 1'b1;
        @(posedge pclk);
        do begin
            @(negedge pclk);
            c++;
            if (c == 1) bus3.req_valid = 1'b0;
            if (bus3.psel != '0) seen_sel = 1'b1;
        end while (!bus3.rsp_valid && c < 20);
        chk("dec_latency", 64'(c), (idx >= 3) ? 64'd1 : 64'd3);
        chk("dec_psel_activity", seen_sel, 64'(idx < 3));
        chk("dec_status", bus3.rsp_status, es);
        chk("dec_rdata", bus3.rsp_rdata, ed);
        @(negedge pclk);
        chk("dec_consumed", {bus3.rsp_valid, bus3.req_ready}, 2'b01);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic sv;
        bus.req_valid = 1'b0;
        bus.req_addr = '0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
        bus.req_strb = '0;
        bus.req_prot = '0;
        bus.rsp_ready = 1'b0;
        bus3.req_valid = 1'b0;
        bus3.req_addr = '0;
        bus3.req_write = 1'b0;
        bus3.req_wdata = '0;
        bus3.req_strb = '0;
        bus3.req_prot = '0;
        bus3.rsp_ready = 1'b1;
        for (int i = 0; i < SC; i++) rmem[i] = INIT[i];
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        chk("reset_state", {bus.req_ready, |{bus.psel, bus.penable, bus.rsp_valid, bus.rsp_status,
            bus.rsp_rdata, bus.paddr, bus.pwdata, bus.pstrb, bus.pprot, bus.pwrite}}, 2'b10);

        run3(20'hC0000);
        run3(20'h40008);
        run3(20'hC1234);
        run3(20'h80000);

        run(20'h80010, 1'b0, '0, 4'hF, 3'b000, 0, 1'b0, 0);
        run(20'h40000, 1'b1, 32'h1234_5678, 4'b0011, 3'b010, 5, 1'b1, 0);
        run(20'h40000, 1'b1, 32'h1234_5678, 4'b0011, 3'b010, 0, 1'b0, 0);
        run(20'h40000, 1'b0, '0, '0, 3'b010, 0, 1'b0, 0);
        run(20'h00004, 1'b0, '0, '0, 3'b101, 255, 1'b0, 0);
        run(20'h00004, 1'b0, '0, '0, 3'b101, 0, 1'b0, 0);
        run(20'hC0000, 1'b1, 32'hCAFE_BABE, 4'hF, 3'b111, 7, 1'b0, 0);
        run(20'hC0000, 1'b0, '0, '0, 3'b000, 8, 1'b0, 0);
        run(20'hC0000, 1'b0, '0, '0, 3'b000, 1, 1'b0, 0);
        run(20'h80000, 1'b0, '0, '0, 3'b100, 2, 1'b0, 10);

        wait_n = 50;
        err_n = 1'b0;
        handshake(20'hC0020, 1'b0, '0, '0, 3'b001);
        @(negedge pclk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge pclk);
        chk("pre_reset_access", {bus.psel, bus.penable}, {4'b1000, 1'b1});
        preset = 1'b1;
        #1;
        chk("reset_outputs", |{bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb,
            bus.pprot, bus.rsp_valid, bus.rsp_rdata, bus.rsp_status}, 0);
        chk("reset_req_ready", bus.req_ready, 1);
        @(negedge pclk);
        preset = 1'b0;
        for (int i = 0; i < SC; i++) rmem[i] = INIT[i];
        sv = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) sv = 1'b1;
        end
        chk("no_rsp_after_reset", sv, 0);

        for (int n = 0; n < 40; n++)
            run({2'($urandom), 18'($urandom)}, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                $urandom_range(0, 10), $urandom_range(0, 3) == 0, $urandom_range(0, 3));

        for (int i = 0; i < SC; i++) chk($sformatf("mem%0d", i), cmem[i], rmem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
